hazard_ctrl_mc: RTL and testbench
=================================

// Module: hazard_ctrl_mc
// PURPOSE
//  Pipeline hazard controller for the 5-stage RV32I core. Successor of the single-cycle hazard unit.
//  Adds a cache-miss stall FSM and a configurable load-use interlock via a bubble counter.
//  Adds M-over-W forwarding priority and optional performance counters.
//  Sits beside the IF/ID/EX/MEM/WB segment registers and drives their Stall*/Flush* inputs plus the EX operand muxes.
// PARAMETERS
//  REG_AW    5   register-address width; register 0 is never forwarded or interlocked
//  LOAD_LAT  1   load-use bubbles inserted (1..3); values >1 support a pipelined D-memory
//  PERF_W    32  width of each performance counter
// PORTS
//  CPU_CLK                  in   1       core clock; all state updates on rising edge
//  CPU_RST                  in   1       synchronous, active-high reset
//  ICacheMiss, DCacheMiss   in   1 each  level miss indications; held until the refill completes
//  BranchE, JalrE, JalD     in   1 each  taken-control-transfer indications
//  Rs1D, Rs2D, Rs1E, Rs2E   in   REG_AW  source register numbers
//  RdE, RdM, RdW            in   REG_AW  destination register numbers
//  RegReadE                 in   2       [1]: rs1 used in EX; [0]: rs2 used in EX
//  MemToRegE, MemToRegM     in   1 each  stage holds a load
//  RegWriteM, RegWriteW     in   3       nonzero = stage writes Rd
//  StallF..StallW           out  1 each  per-stage hold
//  FlushF..FlushW           out  1 each  per-stage clear
//  Forward1E, Forward2E     out  2       00 = regfile, 10 = MEM result, 01 = WB result
//  PerfStallCyc, PerfFlushCnt  out  PERF_W  performance counters (see CONFIGURATION)
// BEHAVIOUR
//  Reset
//   - While CPU_RST=1: all Flush*=1, all Stall*=0, Forward*=00.
//   - Next edge: FSM->RUN, lu_cnt->0, perf counters->0.
//   - Reset mid-miss or mid-interlock abandons that state immediately.
//  FSM state encoding: RUN, I_MISS, D_MISS.
//   - RUN -> D_MISS on DCacheMiss. D_MISS has priority when both misses assert together.
//   - RUN -> I_MISS on ICacheMiss & !DCacheMiss.
//   - I_MISS -> D_MISS on DCacheMiss. I_MISS -> RUN when ICacheMiss=0.
//   - D_MISS -> RUN when DCacheMiss=0. If ICacheMiss=1 at that point, go to I_MISS instead.
//  Per-state outputs
//   - D_MISS: StallF/D/E/M=1 and FlushW=1, i.e. a bubble enters WB. All branch/load-use flushes are suppressed, so the control transfer stays in EX and acts on resume.
//   - I_MISS: StallF=1 and FlushD=1. EX/MEM/WB advance. BranchE/JalrE still flush D and E.
//  Load-use detection
//   - luse = MemToRegE & RdE!=0 & (RdE==Rs1D | RdE==Rs2D), evaluated only in RUN or I_MISS.
//   - When luse=1: StallF=StallD=1 and FlushE=1; lu_cnt loads LOAD_LAT-1.
//   - While lu_cnt!=0: StallF=StallD=1, FlushE=1, and lu_cnt decrements each cycle.
//   - With LOAD_LAT=1 the interlock is purely combinational (1 bubble).
//  Control hazards
//   - BranchE|JalrE: FlushD=FlushE=1.
//   - JalD: FlushD=1.
//   - A control flush overrides a load-use stall in the same cycle: lu_cnt clears, StallF/D=0.
//  Forwarding (per operand, independently)
//   - Select M when RdM!=0 & |RegWriteM & RegReadE bit & RdM==RsE & !(MemToRegM & LOAD_LAT>1).
//   - Otherwise select W under the equivalent W condition.
//   - Otherwise select regfile.
//   - M always beats W when both match.
//   - Forward outputs are combinational and are not gated by stalls.
//  Flush/stall conflict
//   - For any stage where Stall=1, a non-reset Flush is forced to 0.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined:
//   - PerfStallCyc increments each cycle in which StallF=1.
//   - PerfFlushCnt increments each cycle in which BranchE|JalrE|JalD causes a flush.
//   - Both counters saturate at all-ones and clear on CPU_RST.
//  HAZARD_PERF_CNT_EN undefined: counter logic is not built; both outputs are tied to 0.
// STRUCTURE
//  Package hazard_pkg:
//   - FSM state typedef (RUN/I_MISS/D_MISS)
//   - forward-select constants FWD_RF=00, FWD_M=10, FWD_W=01
//  Sub-module hazard_fwd_sel: one instance per EX operand; computes the 2-bit select.
//  Top level: FSM, lu_cnt, stall/flush merge, perf counters.
// TESTING
//  1. CPU_RST=1 for 2 cycles, then 0 -> all Flush*=1 during reset; Flush*=0, Stall*=0, Forward*=00 on the first free cycle.
//  2. RdM=RdW=5, both writing, Rs1E=5, RegReadE=10 -> Forward1E=10. Set RdM=0 -> Forward1E=01.
//  3. LOAD_LAT=2, MemToRegE=1, RdE=7, Rs2D=7 -> StallF/D=1 and FlushE=1 for exactly 2 cycles. Third cycle: all 0.
//  4. DCacheMiss high 4 cycles with BranchE=1 -> StallF/D/E/M=1, FlushW=1, FlushD/E=0 for 4 cycles. Cycle 5: RUN, FlushD=FlushE=1.
//  5. ICacheMiss and DCacheMiss rise together; DCacheMiss drops after 2 cycles, ICacheMiss after 5 -> D_MISS 2 cycles, I_MISS 3 cycles, then RUN.
//  6. HAZARD_PERF_CNT_EN defined, test 3 run once -> PerfStallCyc=2, PerfFlushCnt=0.
//     HAZARD_PERF_CNT_EN undefined -> both counters read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the RV32I hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    I_MISS = 2'd1,
    D_MISS = 2'd2
  } hz_state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_W  = 2'b01;

  // Wide enough to hold LOAD_LAT-1 for LOAD_LAT up to 3.
  localparam int LU_W = 2;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one EX operand; MEM result beats WB result.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              rs_used,
  input  logic [2:0]        reg_write_m,
  input  logic [2:0]        reg_write_w,
  input  logic              mem_to_reg_m,
  output logic [1:0]        fwd_sel
);

  logic hit_m;
  logic hit_w;

  always_comb begin
    // With a pipelined D-memory the load data is not ready in MEM yet.
    hit_m = (rd_m != '0) && (|reg_write_m) && rs_used && (rd_m == rs_e) &&
            !(mem_to_reg_m && (LOAD_LAT > 1));
    hit_w = (rd_w != '0) && (|reg_write_w) && rs_used && (rd_w == rs_e);
    fwd_sel = FWD_RF;
    if (hit_m) begin
      fwd_sel = FWD_M;
    end else if (hit_w) begin
      fwd_sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller: cache-miss FSM, load-use interlock, control flushes, forwarding.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int PERF_W   = 32
) (
  input  logic              CPU_CLK,
  input  logic              CPU_RST,
  input  logic              ICacheMiss,
  input  logic              DCacheMiss,
  input  logic              BranchE,
  input  logic              JalrE,
  input  logic              JalD,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic [1:0]        RegReadE,
  input  logic              MemToRegE,
  input  logic              MemToRegM,
  input  logic [2:0]        RegWriteM,
  input  logic [2:0]        RegWriteW,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              StallW,
  output logic              FlushF,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              FlushW,
  output logic [1:0]        Forward1E,
  output logic [1:0]        Forward2E,
  output logic [PERF_W-1:0] PerfStallCyc,
  output logic [PERF_W-1:0] PerfFlushCnt
);

  hz_state_t       state_q, state_d;
  logic [LU_W-1:0] lu_cnt_q, lu_cnt_d;
  logic            dmiss, imiss, luse, ctrl_flush, lu_stall;
  logic            st_f, st_d, st_e, st_m, st_w;
  logic            fl_f, fl_d, fl_e, fl_m, fl_w;
  logic [1:0]      fwd1_sel, fwd2_sel;

  hazard_fwd_sel #(.REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT)) u_fwd1 (
    .rs_e(Rs1E), .rd_m(RdM), .rd_w(RdW), .rs_used(RegReadE[1]),
    .reg_write_m(RegWriteM), .reg_write_w(RegWriteW),
    .mem_to_reg_m(MemToRegM), .fwd_sel(fwd1_sel)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT)) u_fwd2 (
    .rs_e(Rs2E), .rd_m(RdM), .rd_w(RdW), .rs_used(RegReadE[0]),
    .reg_write_m(RegWriteM), .reg_write_w(RegWriteW),
    .mem_to_reg_m(MemToRegM), .fwd_sel(fwd2_sel)
  );

  // Outputs follow the next state so a miss stalls in the cycle it is raised.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (DCacheMiss)      state_d = D_MISS;
        else if (ICacheMiss) state_d = I_MISS;
      end
      I_MISS: begin
        if (DCacheMiss)      state_d = D_MISS;
        else if (!ICacheMiss) state_d = RUN;
      end
      D_MISS: begin
        if (!DCacheMiss)     state_d = ICacheMiss ? I_MISS : RUN;
      end
      default: state_d = RUN;
    endcase
    dmiss = (state_d == D_MISS);
    imiss = (state_d == I_MISS);
  end

  always_comb begin
    luse       = MemToRegE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D)) && !dmiss;
    ctrl_flush = (BranchE || JalrE || JalD) && !dmiss;
    lu_stall   = (luse || (lu_cnt_q != '0)) && !ctrl_flush && !dmiss;

    // The counter freezes during a D-miss since the whole front end is held.
    lu_cnt_d = lu_cnt_q;
    if (ctrl_flush) begin
      lu_cnt_d = '0;
    end else if (!dmiss) begin
      if (lu_cnt_q != '0)  lu_cnt_d = lu_cnt_q - LU_W'(1);
      else if (luse)       lu_cnt_d = LU_W'(LOAD_LAT - 1);
    end

    st_f = dmiss || imiss || lu_stall;
    st_d = dmiss || lu_stall;
    st_e = dmiss;
    st_m = dmiss;
    st_w = 1'b0;
    fl_f = 1'b0;
    fl_d = imiss || ctrl_flush;
    fl_e = ((BranchE || JalrE) && !dmiss) || lu_stall;
    fl_m = 1'b0;
    fl_w = dmiss;
  end

  always_comb begin
    if (CPU_RST) begin
      {StallF, StallD, StallE, StallM, StallW} = '0;
      {FlushF, FlushD, FlushE, FlushM, FlushW} = '1;
      Forward1E = FWD_RF;
      Forward2E = FWD_RF;
    end else begin
      {StallF, StallD, StallE, StallM, StallW} = {st_f, st_d, st_e, st_m, st_w};
      // A held stage must keep its contents, so its flush is dropped.
      FlushF = fl_f && !st_f;
      FlushD = fl_d && !st_d;
      FlushE = fl_e && !st_e;
      FlushM = fl_m && !st_m;
      FlushW = fl_w && !st_w;
      Forward1E = fwd1_sel;
      Forward2E = fwd2_sel;
    end
  end

  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      state_q  <= RUN;
      lu_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] perf_stall_q, perf_stall_d;
  logic [PERF_W-1:0] perf_flush_q, perf_flush_d;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

  always_comb begin
    perf_stall_d = StallF ? sat_inc(perf_stall_q) : perf_stall_q;
    perf_flush_d = ctrl_flush ? sat_inc(perf_flush_q) : perf_flush_q;
  end

  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign PerfStallCyc = perf_stall_q;
  assign PerfFlushCnt = perf_flush_q;
`else
  assign PerfStallCyc = '0;
  assign PerfFlushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Scoreboard bench for hazard_ctrl_mc (LOAD_LAT=2): stimulus queues expectations, monitor checks.
module tb_hazard_ctrl_mc;

  localparam int PW = 32;
`ifdef HAZARD_PERF_CNT_EN
  localparam logic [PW-1:0] EXP_PS = 32'd2;
`else
  localparam logic [PW-1:0] EXP_PS = 32'd0;
`endif

  logic CPU_CLK = 1'b1;
  logic CPU_RST;
  logic ICacheMiss, DCacheMiss, BranchE, JalrE, JalD;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] RegReadE;
  logic MemToRegE, MemToRegM;
  logic [2:0] RegWriteM, RegWriteW;
  logic StallF, StallD, StallE, StallM, StallW;
  logic FlushF, FlushD, FlushE, FlushM, FlushW;
  logic [1:0] Forward1E, Forward2E;
  logic [PW-1:0] PerfStallCyc, PerfFlushCnt;

  typedef struct {
    string       nm;
    logic [4:0]  st;
    logic [4:0]  fl;
    logic [1:0]  f1;
    logic [1:0]  f2;
    bit          cp;
    logic [PW-1:0] ps;
    logic [PW-1:0] pf;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  hazard_ctrl_mc #(.REG_AW(5), .LOAD_LAT(2), .PERF_W(PW)) dut (
    .CPU_CLK(CPU_CLK), .CPU_RST(CPU_RST),
    .ICacheMiss(ICacheMiss), .DCacheMiss(DCacheMiss),
    .BranchE(BranchE), .JalrE(JalrE), .JalD(JalD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegReadE(RegReadE),
    .MemToRegE(MemToRegE), .MemToRegM(MemToRegM),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushF(FlushF), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .Forward1E(Forward1E), .Forward2E(Forward2E),
    .PerfStallCyc(PerfStallCyc), .PerfFlushCnt(PerfFlushCnt)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  task automatic chk(input string nm, input string fld, input logic [PW-1:0] act,
                     input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
    end
  endtask

  always @(negedge CPU_CLK) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.nm, "stall", PW'({StallF, StallD, StallE, StallM, StallW}), PW'(e.st));
      chk(e.nm, "flush", PW'({FlushF, FlushD, FlushE, FlushM, FlushW}), PW'(e.fl));
      chk(e.nm, "fwd1", PW'(Forward1E), PW'(e.f1));
      chk(e.nm, "fwd2", PW'(Forward2E), PW'(e.f2));
      if (e.cp) begin
        chk(e.nm, "perf_stall", PerfStallCyc, e.ps);
        chk(e.nm, "perf_flush", PerfFlushCnt, e.pf);
      end
    end
  end

  task automatic step(input string nm, input logic [4:0] st, input logic [4:0] fl,
                      input logic [1:0] f1 = 2'b00, input logic [1:0] f2 = 2'b00,
                      input bit cp = 1'b0, input logic [PW-1:0] ps = '0,
                      input logic [PW-1:0] pf = '0);
    exp_t e;
    e.nm = nm; e.st = st; e.fl = fl; e.f1 = f1; e.f2 = f2;
    e.cp = cp; e.ps = ps; e.pf = pf;
    exp_q.push_back(e);
    @(posedge CPU_CLK);
    #1;
  endtask

  task automatic idle();
    ICacheMiss = 0; DCacheMiss = 0; BranchE = 0; JalrE = 0; JalD = 0;
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegReadE = 2'b00; MemToRegE = 0; MemToRegM = 0; RegWriteM = 0; RegWriteW = 0;
  endtask

  initial begin
    idle();
    CPU_RST = 1;
    step("rst0", 5'b00000, 5'b11111);
    RdM = 5; RegWriteM = 3'b001; Rs1E = 5; RegReadE = 2'b10;
    step("rst1_fwd_gated", 5'b00000, 5'b11111);
    idle(); CPU_RST = 0;
    step("free", 5'b00000, 5'b00000);

    // Load-use with two bubbles; EX holds a bubble after the first cycle.
    MemToRegE = 1; RdE = 7; Rs2D = 7;
    step("lu0", 5'b11000, 5'b00100);
    idle();
    step("lu1", 5'b11000, 5'b00100);
    step("lu2", 5'b00000, 5'b00000);
    step("perf", 5'b00000, 5'b00000, 2'b00, 2'b00, 1'b1, EXP_PS, '0);

    MemToRegE = 1; RdE = 0; Rs1D = 0;
    step("lu_x0", 5'b00000, 5'b00000);
    MemToRegE = 1; RdE = 7; Rs1D = 7; BranchE = 1;
    step("lu_br", 5'b00000, 5'b01100);
    idle();
    step("lu_br_after", 5'b00000, 5'b00000);
    JalD = 1;
    step("jald", 5'b00000, 5'b01000);
    idle();

    // Reset in the middle of an interlock drops the remaining bubble.
    MemToRegE = 1; RdE = 9; Rs1D = 9;
    step("lu_mid", 5'b11000, 5'b00100);
    idle(); CPU_RST = 1;
    step("lu_rst", 5'b00000, 5'b11111);
    CPU_RST = 0;
    step("lu_rst_after", 5'b00000, 5'b00000);

    // Forwarding.
    RdM = 5; RdW = 5; RegWriteM = 3'b001; RegWriteW = 3'b001; Rs1E = 5; RegReadE = 2'b10;
    step("fwd_m", 5'b00000, 5'b00000, 2'b10, 2'b00);
    RdM = 0;
    step("fwd_w", 5'b00000, 5'b00000, 2'b01, 2'b00);
    RdM = 5; RegReadE = 2'b00;
    step("fwd_unused", 5'b00000, 5'b00000, 2'b00, 2'b00);
    Rs2E = 5; RegReadE = 2'b01; RegWriteM = 3'b100; MemToRegM = 1;
    step("fwd_load_m", 5'b00000, 5'b00000, 2'b00, 2'b01);
    MemToRegM = 0;
    step("fwd2_m", 5'b00000, 5'b00000, 2'b00, 2'b10);
    RegWriteM = 0; RdW = 0;
    step("fwd_none", 5'b00000, 5'b00000, 2'b00, 2'b00);
    idle();

    // D-miss with a pending branch: branch acts on resume.
    DCacheMiss = 1; BranchE = 1;
    for (int i = 0; i < 4; i++) step("dmiss", 5'b11110, 5'b00001);
    DCacheMiss = 0;
    step("dmiss_resume", 5'b00000, 5'b01100);
    idle();
    step("dmiss_idle", 5'b00000, 5'b00000);

    // Simultaneous misses: D first, then I.
    DCacheMiss = 1; ICacheMiss = 1;
    for (int i = 0; i < 2; i++) step("both_d", 5'b11110, 5'b00001);
    DCacheMiss = 0;
    for (int i = 0; i < 3; i++) step("both_i", 5'b10000, 5'b01000);
    ICacheMiss = 0;
    step("both_run", 5'b00000, 5'b00000);

    // I-miss combined with control transfer and with load-use.
    ICacheMiss = 1; JalrE = 1;
    step("imiss_jalr", 5'b10000, 5'b01100);
    JalrE = 0; MemToRegE = 1; RdE = 3; Rs1D = 3;
    step("imiss_lu", 5'b11000, 5'b00100);
    idle();
    step("imiss_lu_tail", 5'b11000, 5'b00100);
    step("final", 5'b00000, 5'b00000);

    repeat (2) @(posedge CPU_CLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
